// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one AES-128 core among NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining AES_ARB_TIMEOUT_EN.
module aes_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*128-1:0]     req_key_i,
  input  logic [NUM_REQ*128-1:0]     req_pt_i,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  input  logic [NUM_REQ-1:0]         rsp_ready_i,
  output logic [127:0]               rsp_ct_o,
  output logic                       rsp_err_o,
  output logic                       aes_start_o,
  output logic [127:0]               aes_key_o,
  output logic [127:0]               aes_pt_o,
  input  logic                       aes_ready_i,
  input  logic                       aes_done_i,
  input  logic [127:0]               aes_ct_i,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [127:0]      key_q, key_d;
  logic [127:0]      pt_q, pt_d;
  logic [127:0]      ct_q, ct_d;

  logic [NUM_REQ-1:0][127:0] key_arr, pt_arr;
  assign key_arr = req_key_i;
  assign pt_arr  = req_pt_i;

  logic            hi_found, lo_found, pick_found;
  logic [ID_W-1:0] hi_idx, lo_idx, pick_idx;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

  // Lowest valid index above last grant wins; otherwise wrap to lowest valid overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
        if (i > int'(last_q)) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    pick_found = lo_found;
    pick_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    key_d       = key_q;
    pt_d        = pt_q;
    ct_d        = ct_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    aes_start_o = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
    tmo_d       = tmo_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (aes_ready_i && pick_found) begin
          req_ready_o = NUM_REQ'(1) << pick_idx;
          grant_d     = pick_idx;
          key_d       = key_arr[pick_idx];
          pt_d        = pt_arr[pick_idx];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        aes_start_o = 1'b1;
        state_d     = S_WAIT;
`ifdef AES_ARB_TIMEOUT_EN
        tmo_d       = '0;
`endif
      end
      S_WAIT: begin
        if (aes_done_i) begin
          ct_d    = aes_ct_i;
          state_d = S_RESP;
`ifdef AES_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          ct_d    = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
`endif
        end
      end
      S_RESP: begin
        rsp_valid_o = NUM_REQ'(1) << grant_q;
        if (rsp_ready_i[grant_q]) begin
          last_d  = grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      grant_q <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      ct_q    <= ct_d;
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign rsp_err_o = (state_q == S_RESP) && err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  assign rsp_ct_o   = ct_q;
  assign aes_key_o  = key_q;
  assign aes_pt_o   = pt_q;
  assign busy_o     = (state_q != S_IDLE);
  assign grant_id_o = grant_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter: vector table of round-robin jobs plus
// hand-written reset, back-pressure, core-not-ready and timeout sequences.
module tb_aes_req_arbiter;
  localparam int N   = 4;
  localparam int TMO = 8;
  localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [N*128-1:0] req_key_i, req_pt_i;
  logic [127:0]     rsp_ct_o, aes_key_o, aes_pt_o;
  logic             rsp_err_o, aes_start_o, aes_ready_i, aes_done_i, busy_o;
  logic [127:0]     aes_ct_i = '0;
  logic [1:0]       grant_id_o;

  logic [N-1:0][127:0] keys, pts;
  assign req_key_i = keys;
  assign req_pt_i  = pts;

  always #5 clk = ~clk;

  aes_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_key_i(req_key_i), .req_pt_i(req_pt_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_ct_o(rsp_ct_o), .rsp_err_o(rsp_err_o),
    .aes_start_o(aes_start_o), .aes_key_o(aes_key_o), .aes_pt_o(aes_pt_o),
    .aes_ready_i(aes_ready_i), .aes_done_i(aes_done_i), .aes_ct_i(aes_ct_i),
    .busy_o(busy_o), .grant_id_o(grant_id_o)
  );

  // Stub core: done pulse stub_lat edges after start, carrying a known result.
  logic         stub_done = 1'b0;
  logic         tb_done;
  logic         stub_en;
  int           stub_cnt = 0;
  int           stub_lat;
  logic [127:0] stub_k = '0, stub_p = '0;
  assign aes_done_i = stub_done | tb_done;

  function automatic logic [127:0] core_model(input logic [127:0] k, input logic [127:0] p);
    if (k == K0 && p == P0) return CT0;
    return k ^ p;
  endfunction

  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (rst) stub_cnt <= 0;
    else if (aes_start_o) begin
      stub_cnt <= stub_lat;
      stub_k   <= aes_key_o;
      stub_p   <= aes_pt_o;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && stub_en) begin
        stub_done <= 1'b1;
        aes_ct_i  <= core_model(stub_k, stub_p);
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int g);
    return 4'(1) << g;
  endfunction

  task automatic run_job(input logic [3:0] mask, input int g, input logic [127:0] ect,
                         input logic eerr, input int hold, output int lat);
    int   n;
    int   starts;
    logic ok;
    lat = -1;
    req_valid_i = mask;
    rsp_ready_i = '0;
    #1;
    n = 0;
    while (req_ready_o == '0 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("grant_ready", 128'(req_ready_o), 128'(oh(g)));
    chk("grant_wait", 128'(n), 128'(0));
    if (req_ready_o == '0) return;
    @(negedge clk); #1;
    chk("start_pulse", 128'(aes_start_o), 128'(1'b1));
    chk("core_key", aes_key_o, keys[g]);
    chk("core_pt", aes_pt_o, pts[g]);
    chk("grant_id", 128'(grant_id_o), 128'(g));
    n = 0;
    starts = 0;
    do begin
      @(negedge clk); #1; n++;
      if (aes_start_o) starts++;
    end while (rsp_valid_o == '0 && n < 60);
    lat = n;
    chk("single_start", 128'(starts), 128'(0));
    chk("rsp_valid", 128'(rsp_valid_o), 128'(oh(g)));
    chk("rsp_ct", rsp_ct_o, ect);
    chk("rsp_err", 128'(rsp_err_o), 128'(eerr));
    ok = 1'b1;
    for (int c = 0; c < hold; c++) begin
      if (c == hold - 1) rsp_ready_i = ~oh(g);
      @(negedge clk); #1;
      if (rsp_valid_o != oh(g) || rsp_ct_o != ect || req_ready_o != '0 ||
          aes_start_o || !busy_o || aes_key_o != keys[g]) ok = 1'b0;
    end
    if (hold > 0) chk("resp_hold", 128'(ok), 128'(1'b1));
    rsp_ready_i = oh(g);
    @(negedge clk); #1;
    chk("rsp_done", 128'({busy_o, rsp_valid_o}), 128'(0));
    rsp_ready_i = '0;
  endtask

  typedef struct {
    logic [3:0]   valid;
    int           g;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic ok;
    keys[0] = K0;  pts[0] = P0;
    keys[1] = 128'h11110001_11110001_11110001_11110001;
    pts[1]  = 128'ha5a50001_a5a50001_a5a50001_a5a50001;
    keys[2] = 128'h22220002_22220002_22220002_22220002;
    pts[2]  = 128'h5a5a0002_5a5a0002_5a5a0002_5a5a0002;
    keys[3] = 128'h33330003_33330003_33330003_33330003;
    pts[3]  = 128'h0f0f0003_0f0f0003_0f0f0003_0f0f0003;

    vecs[0]  = '{4'b0001, 0, CT0};
    vecs[1]  = '{4'b1111, 1, keys[1] ^ pts[1]};
    vecs[2]  = '{4'b1111, 2, keys[2] ^ pts[2]};
    vecs[3]  = '{4'b1111, 3, keys[3] ^ pts[3]};
    vecs[4]  = '{4'b1111, 0, CT0};
    vecs[5]  = '{4'b1010, 1, keys[1] ^ pts[1]};
    vecs[6]  = '{4'b1010, 3, keys[3] ^ pts[3]};
    vecs[7]  = '{4'b0110, 1, keys[1] ^ pts[1]};
    vecs[8]  = '{4'b0001, 0, CT0};
    vecs[9]  = '{4'b1000, 3, keys[3] ^ pts[3]};
    vecs[10] = '{4'b0100, 2, keys[2] ^ pts[2]};
    vecs[11] = '{4'b0011, 0, CT0};

    rst = 1'b1; req_valid_i = '0; rsp_ready_i = '0;
    aes_ready_i = 1'b1; tb_done = 1'b0; stub_en = 1'b1; stub_lat = 3;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctl", 128'({busy_o, req_ready_o, rsp_valid_o, aes_start_o, rsp_err_o, grant_id_o}), 128'(0));
    chk("reset_data", aes_key_o | aes_pt_o | rsp_ct_o, 128'(0));
    rst = 1'b0;

    // Round-robin job table; requester 0 carries the FIPS-197 vector.
    for (int i = 0; i < 12; i++)
      run_job(vecs[i].valid, vecs[i].g, vecs[i].ct, 1'b0, 1, lat);

    // Reset while the core is busy.
    req_valid_i = 4'b0100; #1;
    chk("t5_ready", 128'(req_ready_o), 128'(4'b0100));
    @(negedge clk); #1;
    req_valid_i = '0;
    @(negedge clk); #1;
    chk("t5_wait_busy", 128'(busy_o), 128'(1'b1));
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("t5_rst_ctl", 128'({busy_o, req_ready_o, rsp_valid_o, aes_start_o, rsp_err_o, grant_id_o}), 128'(0));
    chk("t5_rst_data", aes_key_o | aes_pt_o | rsp_ct_o, 128'(0));
    tb_done = 1'b1;
    @(negedge clk);
    tb_done = 1'b0;
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk); #1;
      if (busy_o || rsp_valid_o != '0 || aes_start_o) ok = 1'b0;
    end
    chk("t5_stray_done", 128'(ok), 128'(1'b1));

    // Core not ready blocks every grant.
    aes_ready_i = 1'b0;
    req_valid_i = 4'b1111;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      if (req_ready_o != '0 || busy_o) ok = 1'b0;
    end
    chk("t4_blocked", 128'(ok), 128'(1'b1));
    aes_ready_i = 1'b1; #1;
    chk("t4_first_grant", 128'(req_ready_o), 128'(4'b0001));
    run_job(4'b1111, 0, CT0, 1'b0, 1, lat);

    // Long back-pressure on the response channel.
    run_job(4'b1111, 1, keys[1] ^ pts[1], 1'b0, 20, lat);

`ifdef AES_ARB_TIMEOUT_EN
    stub_en = 1'b0;
    run_job(4'b1000, 3, 128'(0), 1'b1, 1, lat);
    chk("t6_latency", 128'(lat), 128'(TMO + 1));
    stub_en = 1'b1;
`endif

    run_job(4'b0001, 0, CT0, 1'b0, 1, lat);
    req_valid_i = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
